// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtraction controller: one shared full-subtract cell (two
// cascaded half-subtract stages) walks LSB-first across a WIDTH-bit pair.
module serial_sub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] diff_sh_q, diff_sh_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             borrow_q, borrow_d;
   logic             bout_q, bout_d;
   logic             done_q, done_d;

   logic d1, b1, d_bit, b2, bout;
   logic [WIDTH-1:0] diff_nx;

   // Shared bit cell: stage 1 on the operand bits, stage 2 folds in borrow.
   always_comb begin
      d1    = a_sh_q[0] ^ b_sh_q[0];
      b1    = ~a_sh_q[0] & b_sh_q[0];
      d_bit = d1 ^ borrow_q;
      b2    = ~d1 & borrow_q;
      bout  = b1 | b2;
      diff_nx = {d_bit, diff_sh_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d   = state_q;
      a_sh_d    = a_sh_q;
      b_sh_d    = b_sh_q;
      diff_sh_d = diff_sh_q;
      diff_d    = diff_q;
      cnt_d     = cnt_q;
      borrow_d  = borrow_q;
      bout_d    = bout_q;
      done_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               a_sh_d    = a;
               b_sh_d    = b;
               borrow_d  = 1'b0;
               cnt_d     = '0;
               diff_sh_d = '0;
               diff_d    = '0;
               bout_d    = 1'b0;
            end
         end
         RUN: begin
            a_sh_d    = a_sh_q >> 1;
            b_sh_d    = b_sh_q >> 1;
            diff_sh_d = diff_nx;
            borrow_d  = bout;
            cnt_d     = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               diff_d  = diff_nx;
               bout_d  = bout;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         a_sh_q    <= '0;
         b_sh_q    <= '0;
         diff_sh_q <= '0;
         diff_q    <= '0;
         cnt_q     <= '0;
         borrow_q  <= 1'b0;
         bout_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_sh_q    <= a_sh_d;
         b_sh_q    <= b_sh_d;
         diff_sh_q <= diff_sh_d;
         diff_q    <= diff_d;
         cnt_q     <= cnt_d;
         borrow_q  <= borrow_d;
         bout_q    <= bout_d;
         done_q    <= done_d;
      end
   end

   assign ready      = (state_q == IDLE);
   assign busy       = (state_q == RUN);
   assign done       = done_q;
   assign diff       = diff_q;
   assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl: arithmetic reference model, directed
// cases followed by randomized start/reset traffic.
module tb_serial_sub_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;

   int tests;
   int fails;

   logic [W:0] exp_q[$];

   serial_sub_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a         (a),
      .b         (b),
      .ready     (ready),
      .busy      (busy),
      .done      (done),
      .diff      (diff),
      .borrow_out(borrow_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model + monitor: tracks the contract cycle by cycle.
   initial begin : monitor
      bit         m_busy;
      int         m_cnt;
      logic [W-1:0] m_diff;
      logic       m_bo;
      bit         exp_done;
      logic       r, s;
      logic [W-1:0] aa, bb;
      logic [W:0] e;
      m_busy = 0;
      m_cnt  = 0;
      m_diff = '0;
      m_bo   = 1'b0;
      forever begin
         @(posedge clk);
         r  = rst;
         s  = start;
         aa = a;
         bb = b;
         exp_done = 0;
         if (r) begin
            m_busy = 0;
            m_cnt  = 0;
            m_diff = '0;
            m_bo   = 1'b0;
            exp_q.delete();
         end else if (!m_busy) begin
            if (s) begin
               exp_q.push_back({(aa < bb), W'(aa - bb)});
               m_busy = 1;
               m_cnt  = W;
               m_diff = '0;
               m_bo   = 1'b0;
            end
         end else begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_busy   = 0;
               exp_done = 1;
            end
         end
         #3;
         chk("ready", 32'(ready), 32'(!m_busy));
         chk("busy", 32'(busy), 32'(m_busy));
         chk("done", 32'(done), 32'(exp_done));
         if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("result_pending", 32'(0), 32'(1));
            end else begin
               e = exp_q.pop_front();
               chk("diff", 32'(diff), 32'(e[W-1:0]));
               chk("borrow_out", 32'(borrow_out), 32'(e[W]));
               m_diff = e[W-1:0];
               m_bo   = e[W];
            end
         end else begin
            chk("diff_hold", 32'(diff), 32'(m_diff));
            chk("borrow_hold", 32'(borrow_out), 32'(m_bo));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv);
      a = av;
      b = bv;
      start = 1'b1;
      step(1);
      start = 1'b0;
      a = $urandom;
      b = $urandom;
      step(W + 1);
   endtask

   initial begin : stim
      tests = 0;
      fails = 0;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      step(2);
      rst = 1'b0;
      step(1);

      op(8'h5A, 8'h3C);
      op(8'h00, 8'h01);
      op(8'h01, 8'h00);
      op(8'hA5, 8'hA5);
      op(8'h00, 8'hFF);

      // Start while busy must be ignored.
      a = 8'h10; b = 8'h01; start = 1'b1;
      step(1);
      start = 1'b0;
      step(2);
      a = 8'hFF; b = 8'h00; start = 1'b1;
      step(1);
      start = 1'b0;
      step(W + 2);

      // Reset mid-run aborts without done.
      a = 8'h80; b = 8'h7F; start = 1'b1;
      step(1);
      start = 1'b0;
      step(3);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(2);
      op(8'h03, 8'h05);

      // Continuous start: one result every W+1 cycles.
      a = 8'h20; b = 8'h10; start = 1'b1;
      step(3 * (W + 1));
      start = 1'b0;
      step(W + 2);

      // Random traffic with occasional reset.
      for (int i = 0; i < 600; i++) begin
         a     = $urandom;
         b     = $urandom;
         start = ($urandom_range(0, 2) == 0);
         rst   = ($urandom_range(0, 79) == 0);
         step(1);
      end
      start = 1'b0;
      rst   = 1'b0;
      step(W + 3);

      chk("queue_drained", 32'(exp_q.size()), 32'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial subtraction controller that time-shares one single-bit subtractor cell across a WIDTH-bit operand pair. On a start request it latches both operands, feeds one bit pair per clock through a full-subtract stage built from two cascaded half-subtract stages, and registers the running borrow between bits. It shifts the difference into a result register and reports the final difference and borrow with a one-cycle done pulse. It sits between a requesting master and the shared subtractor bit cell, and provides a start/ready/done handshake.

## Interface
- WIDTH, default 8: operand and result width in bits, minimum 2.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a subtraction; sampled only while ready=1.
- a  input  WIDTH  minuend; sampled on the accepting edge only.
- b  input  WIDTH  subtrahend; sampled on the accepting edge only.
- ready  output  1  high in IDLE; start is accepted when ready=1.
- busy  output  1  high in RUN (equals ~ready).
- done  output  1  one-cycle pulse when the result becomes valid.
- diff  output  WIDTH  a - b mod 2^WIDTH; held until the next accepted start.
- borrow_out  output  1  final borrow (1 when a < b unsigned); held with diff.

## Operation
- States:
  - IDLE: ready=1, busy=0.
  - RUN: ready=0, busy=1.
- IDLE -> RUN when start=1. On that edge:
  - a_sh<=a, b_sh<=b, borrow<=0, bit_cnt<=0.
  - diff_sh<=0, diff<=0, borrow_out<=0.
- RUN, each edge, processes bit pair (a_sh[0], b_sh[0]) with bin=borrow:
  - Stage 1 (half subtract): d1=a_sh[0]^b_sh[0]; b1=~a_sh[0]&b_sh[0].
  - Stage 2 (half subtract): d=d1^bin; b2=~d1&bin.
  - Borrow: bout=b1|b2.
  - a_sh and b_sh shift right by 1; diff_sh shifts right with d inserted at the MSB.
  - borrow<=bout; bit_cnt<=bit_cnt+1.
- RUN -> IDLE on the edge where bit_cnt==WIDTH-1. On that edge:
  - diff<=final shifted value; borrow_out<=bout; done<=1.
- done is 0 on every other edge.
- start while busy=1 is ignored. No queuing; a and b are not re-sampled.
- diff and borrow_out change only on the completion edge or the accepting edge (cleared to 0 on accept).
- Reset (any state, including mid-RUN): aborts the operation.
  - state<=IDLE; all shift registers, bit_cnt and borrow <=0.
  - Outputs: ready=1, busy=0, done=0, diff=0, borrow_out=0.
- bit_cnt is $clog2(WIDTH) bits wide and never wraps past WIDTH-1 in RUN.

## Timing
- Accepting edge E0: start=1 and ready=1 sampled. busy=1 and ready=0 from E0 onward.
- Edges E1..EW process bits 0..WIDTH-1.
- At EW: done=1, diff/borrow_out valid, ready=1. Latency from accepting edge to done is WIDTH cycles.
- done is high for exactly one cycle (E(W) to E(W+1)) unless rst intervenes.
- Back-to-back: start=1 in the done cycle is accepted at E(W+1). That edge clears diff and borrow_out and starts a new operation. Throughput is one result per WIDTH+1 cycles.
- Reset values of all outputs: ready=1, busy=0, done=0, diff=0, borrow_out=0.
- rst has priority over start on the same edge.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, start for 1 cycle -> done exactly 8 cycles later; diff=0x1E, borrow_out=0; busy high for 8 cycles.
- a=0x00, b=0x01 -> diff=0xFF, borrow_out=1. Also a=0x01, b=0x00 -> diff=0x01, borrow_out=0.
- a=0xA5, b=0xA5 -> diff=0x00, borrow_out=0. Then a=0x00, b=0xFF -> diff=0x01, borrow_out=1.
- Start a=0x10, b=0x01. Three cycles later, pulse start with a=0xFF, b=0x00 -> second request ignored; result diff=0x0F, borrow_out=0; exactly one done pulse.
- Start a=0x80, b=0x7F. Assert rst at cycle 4 of RUN -> next cycle ready=1, busy=0, diff=0, borrow_out=0, and no done pulse. A following start with a=0x03, b=0x05 -> diff=0xFE, borrow_out=1 after 8 cycles.
- Hold start=1 continuously with a=0x20, b=0x10 -> done every 9 cycles with diff=0x10 each time. diff reads 0 between the accepting edge and completion.
